// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding
// and the parameter sanity check used at elaboration.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit width_ok(int width, int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry slice from per-bit generate/propagate.
// Also exposes the carry into the slice MSB for overflow detection.
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = p ^ c[SEG-1:0];
        cout = c[SEG];
        cmsb = c[SEG-1];
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one register stage per SEG-bit
// ripple segment, with operand skew / result de-skew and a stalling handshake.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (!width_ok(WIDTH, SEG)) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    // Per-stage registers; stage k holds the result of segments 0..k.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic              op_q  [STAGES];
    logic              op_d  [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic              ovf_q, ovf_d;

    // Values presented to each stage by its predecessor (or by the ports).
    logic [STAGES-1:0] src_v;
    logic              src_op  [STAGES];
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_res [STAGES];

    logic [STAGES-1:0][SEG-1:0] seg_a;
    logic [STAGES-1:0][SEG-1:0] seg_b;
    logic [STAGES-1:0][SEG-1:0] seg_s;
    logic [STAGES-1:0]          seg_ci;
    logic [STAGES-1:0]          seg_co;
    logic [STAGES-1:0]          seg_cm;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        int prev;
        prev = 0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_v[k]   = in_valid;
                src_op[k]  = in_op;
                src_a[k]   = in_a;
                src_b[k]   = in_b;
                src_res[k] = '0;
                // Subtract is A + ~B + ~cin, so the borrow-in is inverted here.
                seg_ci[k]  = in_cin ^ (in_op == OP_SUB);
            end else begin
                src_v[k]   = v_q[prev];
                src_op[k]  = op_q[prev];
                src_a[k]   = a_q[prev];
                src_b[k]   = b_q[prev];
                src_res[k] = res_q[prev];
                seg_ci[k]  = c_q[prev];
            end
            seg_a[k] = src_a[k][k*SEG +: SEG];
            seg_b[k] = src_b[k][k*SEG +: SEG] ^ {SEG{src_op[k] == OP_SUB}};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_seg #(.SEG(SEG)) u_seg (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .cin  (seg_ci[k]),
            .s    (seg_s[k]),
            .cout (seg_co[k]),
            .cmsb (seg_cm[k])
        );
    end

    always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        ovf_d = ovf_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_d[k]                   = src_v[k];
                op_d[k]                  = src_op[k];
                a_d[k]                   = src_a[k];
                b_d[k]                   = src_b[k];
                res_d[k]                 = src_res[k];
                res_d[k][k*SEG +: SEG]   = seg_s[k];
                c_d[k]                   = seg_co[k];
            end
            ovf_d = seg_cm[STAGES-1] ^ seg_co[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            op_q  <= '{default: '0};
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            res_q <= '{default: '0};
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = res_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule
